// File: rtl/prime_pkg.sv
// Shared types and sizing helpers for the prime stream generator.
package prime_pkg;

  localparam int PRIME_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_BOUND  = 3'd2,
    S_DIVIDE = 3'd3,
    S_EMIT   = 3'd4,
    S_DONE   = 3'd5
  } prime_state_t;

  // Width that holds d*d without overflow for a WIDTH-bit divisor.
  function automatic int sq_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/prime_stream_gen_if.sv
// Control and prime output stream of the prime stream generator.
interface prime_stream_gen_if
  import prime_pkg::*;
#(
  parameter int WIDTH = PRIME_WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] limit;
  logic             busy;
  logic             prime_valid;
  logic             prime_ready;
  logic [WIDTH-1:0] prime_data;
  logic             done;
  logic [WIDTH-1:0] count;

  // Stream handshake: a prime moves on a rising edge where prime_valid && prime_ready.
  // Once raised, prime_valid stays high and prime_data stays unchanged until that transfer.
  modport master (
    input  start, limit, prime_ready,
    output busy, prime_valid, prime_data, done, count
  );

  modport slave (
    output start, limit, prime_ready,
    input  busy, prime_valid, prime_data, done, count
  );

endinterface

// File: rtl/prime_serial_rem.sv
// Serial restoring remainder unit: one quotient bit per cycle, rem_valid WIDTH cycles after rem_start.
module prime_serial_rem #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rem_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             rem_valid,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [WIDTH-1:0] src_r, src_q, src_d, next_r;
  logic [WIDTH:0]   trial, diff;
  logic [CW-1:0]    cnt_q;
  logic             active_q;

  // The start cycle already performs the first step on the fresh operands.
  always_comb begin
    src_r  = rem_start ? '0 : r_q;
    src_q  = rem_start ? dividend : q_q;
    src_d  = rem_start ? divisor : d_q;
    trial  = {src_r, src_q[WIDTH-1]};
    diff   = trial - {1'b0, src_d};
    next_r = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      active_q  <= 1'b0;
      rem_valid <= 1'b0;
    end else begin
      rem_valid <= 1'b0;
      if (rem_start) begin
        r_q      <= next_r;
        q_q      <= dividend << 1;
        d_q      <= divisor;
        cnt_q    <= CW'(WIDTH - 1);
        active_q <= 1'b1;
      end else if (active_q) begin
        r_q   <= next_r;
        q_q   <= q_q << 1;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          active_q  <= 1'b0;
          rem_valid <= 1'b1;
        end
      end
    end
  end

  assign rem = r_q;

endmodule

// File: rtl/prime_stream_gen.sv
// Enumerates every prime in [2, limit] by trial division and streams them out in ascending order.
module prime_stream_gen
  import prime_pkg::*;
#(
  parameter int WIDTH = PRIME_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  prime_stream_gen_if.master bus,
  output prime_state_t       state_dbg
);

  localparam int SQW = sq_width(WIDTH);

  prime_state_t     state;
  logic [WIDTH-1:0] limit_q, cand_q, div_q;
  logic             lim_small_q;
  logic             busy_q, valid_q, done_q;
  logic [WIDTH-1:0] data_q, count_q;
  logic             rem_start, rem_valid;
  logic [WIDTH-1:0] rem;
  logic [SQW-1:0]   div_sq;
  logic             div_gt, at_limit;

  // Square at double width so the d*d > c test never overflows.
  assign div_sq   = SQW'(div_q) * SQW'(div_q);
  assign div_gt   = div_sq > SQW'(cand_q);
  assign at_limit = (cand_q == limit_q);

  prime_serial_rem #(.WIDTH(WIDTH)) u_rem (
    .clk       (clk),
    .rst       (rst),
    .rem_start (rem_start),
    .dividend  (cand_q),
    .divisor   (div_q),
    .rem_valid (rem_valid),
    .rem       (rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      limit_q     <= '0;
      cand_q      <= '0;
      div_q       <= '0;
      lim_small_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
      count_q     <= '0;
      rem_start   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rem_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            limit_q     <= bus.limit;
            lim_small_q <= (bus.limit < WIDTH'(2));
            count_q     <= '0;
            cand_q      <= WIDTH'(2);
            busy_q      <= 1'b1;
            state       <= S_INIT;
          end
        end
        // An empty range still spends one cycle here so done lands two cycles after start.
        S_INIT: begin
          if (lim_small_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_DONE;
          end else begin
            div_q <= WIDTH'(2);
            state <= S_BOUND;
          end
        end
        S_BOUND: begin
          if (div_gt) begin
            valid_q <= 1'b1;
            data_q  <= cand_q;
            state   <= S_EMIT;
          end else begin
            rem_start <= 1'b1;
            state     <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          if (rem_valid) begin
            if (rem != '0) begin
              div_q <= div_q + 1'b1;
              state <= S_BOUND;
            end else if (at_limit) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= S_DONE;
            end else begin
              cand_q <= cand_q + 1'b1;
              state  <= S_INIT;
            end
          end
        end
        // Limit test precedes the increment so the candidate never wraps at all-ones.
        S_EMIT: begin
          if (bus.prime_ready) begin
            valid_q <= 1'b0;
            count_q <= count_q + 1'b1;
            if (at_limit) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= S_DONE;
            end else begin
              cand_q <= cand_q + 1'b1;
              state  <= S_INIT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.prime_valid = valid_q;
  assign bus.prime_data  = data_q;
  assign bus.done        = done_q;
  assign bus.count       = count_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_prime_stream_gen.sv
// Scoreboard bench for prime_stream_gen: sieve reference model, decoupled monitors, WIDTH 16 and 8 instances.
module tb_prime_stream_gen;
  import prime_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;
  int ready_mode = 0;   // 0: high, 1: random, 2: low

  prime_stream_gen_if #(.WIDTH(16)) bus16 ();
  prime_stream_gen_if #(.WIDTH(8))  bus8 ();
  prime_state_t state16, state8;

  prime_stream_gen #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.master), .state_dbg(state16));
  prime_stream_gen #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.master),  .state_dbg(state8));

  // ---------------- scoreboard state ----------------
  logic [15:0] exp16_q[$];
  logic [7:0]  exp8_q[$];
  int exp_total16, start_cyc;
  int done16 = 0, done_base16 = 0, done_cyc16 = 0, first_valid16 = -1, n_valid16 = 0, last_count16 = 0;
  int done8 = 0, done_base8 = 0, last_count8 = 0, last_data8 = 0;
  bit hold16 = 0;
  logic [15:0] hold_data16;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k * k <= n; k++)
      if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: sieve of Eratosthenes over [0, lim].
  task automatic model16(input int lim);
    bit comp[256];
    foreach (comp[i]) comp[i] = 1'b0;
    for (int i = 2; i <= lim; i++)
      if (!comp[i]) begin
        exp16_q.push_back(16'(i));
        for (int j = i * i; j <= lim; j += i) comp[j] = 1'b1;
      end
  endtask

  task automatic model8(input int lim);
    bit comp[256];
    foreach (comp[i]) comp[i] = 1'b0;
    for (int i = 2; i <= lim; i++)
      if (!comp[i]) begin
        exp8_q.push_back(8'(i));
        for (int j = i * i; j <= lim; j += i) comp[j] = 1'b1;
      end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst) begin
      hold16 = 1'b0;
    end else begin
      if (hold16) begin
        chk("hold_valid16", bus16.prime_valid, 1);
        chk("hold_data16", bus16.prime_data, hold_data16);
      end
      if (bus16.prime_valid) begin
        n_valid16++;
        if (first_valid16 < 0) first_valid16 = cyc;
      end
      if (bus16.prime_valid && bus16.prime_ready) begin
        chk("is_prime16", is_prime(int'(bus16.prime_data)), 1);
        if (exp16_q.size() == 0) chk("unexpected_prime16", bus16.prime_data, 0);
        else chk("stream16", bus16.prime_data, exp16_q.pop_front());
      end
      hold16      = bus16.prime_valid && !bus16.prime_ready;
      hold_data16 = bus16.prime_data;
      if (bus16.done) begin
        done16++;
        done_cyc16   = cyc;
        last_count16 = int'(bus16.count);
        chk("busy_at_done16", bus16.busy, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus8.prime_valid && bus8.prime_ready) begin
        chk("is_prime8", is_prime(int'(bus8.prime_data)), 1);
        last_data8 = int'(bus8.prime_data);
        if (exp8_q.size() == 0) chk("unexpected_prime8", bus8.prime_data, 0);
        else chk("stream8", bus8.prime_data, exp8_q.pop_front());
      end
      if (bus8.done) begin
        done8++;
        last_count8 = int'(bus8.count);
        chk("busy_at_done8", bus8.busy, 0);
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    bus16.prime_ready = 1'b1;
    bus8.prime_ready  = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       begin bus16.prime_ready = 1'b1; bus8.prime_ready = 1'b1; end
        1:       begin bus16.prime_ready = 1'($urandom_range(0, 1)); bus8.prime_ready = 1'($urandom_range(0, 1)); end
        default: begin bus16.prime_ready = 1'b0; bus8.prime_ready = 1'b0; end
      endcase
    end
  end

  task automatic start16(input int lim);
    model16(lim);
    exp_total16   = exp16_q.size();
    n_valid16     = 0;
    first_valid16 = -1;
    done_base16   = done16;
    @(posedge clk); #1;
    bus16.start = 1'b1;
    bus16.limit = 16'(lim);
    start_cyc   = cyc;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    bus16.limit = 16'($urandom);
    chk("busy_rise16", bus16.busy, 1);
  endtask

  task automatic finish16(input string tag, input int exp_cnt, input int budget);
    int i = 0;
    while (done16 == done_base16 && i < budget) begin
      @(posedge clk);
      i++;
    end
    if (done16 == done_base16) chk({tag, "_timeout"}, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_pulses"}, done16 - done_base16, 1);
    chk({tag, "_count_at_done"}, last_count16, exp_cnt);
    chk({tag, "_count_hold"}, bus16.count, exp_cnt);
    chk({tag, "_busy_after"}, bus16.busy, 0);
    chk({tag, "_queue_empty"}, exp16_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int i;
    bus16.start = 1'b0; bus16.limit = '0;
    bus8.start  = 1'b0; bus8.limit  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy16", bus16.busy, 0);
    chk("rst_valid16", bus16.prime_valid, 0);
    chk("rst_done16", bus16.done, 0);
    chk("rst_data16", bus16.prime_data, 0);
    chk("rst_count16", bus16.count, 0);
    chk("rst_valid8", bus8.prime_valid, 0);
    chk("rst_count8", bus8.count, 0);
    rst = 1'b0;

    // limit 20, ready high: fixed first-prime latency
    ready_mode = 0;
    start16(20);
    finish16("lim20", 8, 5000);
    chk("lim20_first_latency", first_valid16 - start_cyc, 3);

    // empty and single-prime ranges
    for (int l = 0; l < 2; l++) begin
      start16(l);
      finish16("lim_small", 0, 50);
      chk("lim_small_no_valid", n_valid16, 0);
      chk("lim_small_done_lat", done_cyc16 - start_cyc, 2);
    end
    start16(2);
    finish16("lim2", 1, 100);

    // backpressure: ready low for 50 cycles once valid rises, then random
    ready_mode = 2;
    start16(10);
    i = 0;
    while (!bus16.prime_valid && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    chk("bp_valid_rose", bus16.prime_valid, 1);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", bus16.prime_valid, 1);
      chk("bp_data", bus16.prime_data, 2);
    end
    ready_mode = 1;
    finish16("bp", 4, 5000);

    // randomized limits and ready
    for (int r = 0; r < 3; r++) begin
      ready_mode = $urandom_range(0, 1);
      start16($urandom_range(0, 150));
      finish16("rand", exp_total16, 20000);
    end

    // start while busy is ignored
    ready_mode = 1;
    start16(100);
    repeat (30) @(posedge clk);
    #1;
    bus16.start = 1'b1;
    bus16.limit = 16'd5;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    finish16("ignore_start", 25, 20000);

    // reset during a divide, then a fresh run
    ready_mode = 0;
    start16(100);
    i = 0;
    while (state16 != S_DIVIDE && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    chk("reached_divide", state16 == S_DIVIDE, 1);
    rst = 1'b1;
    exp16_q.delete();
    @(posedge clk); #1;
    chk("mid_rst_busy", bus16.busy, 0);
    chk("mid_rst_valid", bus16.prime_valid, 0);
    chk("mid_rst_done", bus16.done, 0);
    chk("mid_rst_data", bus16.prime_data, 0);
    chk("mid_rst_count", bus16.count, 0);
    chk("mid_rst_state", state16 == S_IDLE, 1);
    rst = 1'b0;
    start16(7);
    finish16("after_rst", 4, 3000);

    // WIDTH 8 full range: candidate must stop at 255 without wrapping
    ready_mode = 1;
    model8(255);
    done_base8 = done8;
    @(posedge clk); #1;
    bus8.start = 1'b1;
    bus8.limit = 8'd255;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    i = 0;
    while (done8 == done_base8 && i < 30000) begin
      @(posedge clk);
      i++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("w8_done_pulses", done8 - done_base8, 1);
    chk("w8_count", last_count8, 54);
    chk("w8_last_prime", last_data8, 251);
    chk("w8_queue_empty", exp8_q.size(), 0);
    chk("w8_busy_after", bus8.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
